// File: rtl/vx_vec_dispatch_router_if.sv
// Operand-beat stream into the dispatch router and the per-unit execute-lane outputs.
// master = operand collector / execute units side, slave = router side.
interface vx_vec_dispatch_router_if #(
    parameter int NUM_EX    = 4,
    parameter int EX_BITS   = 2,
    parameter int WIS_W     = 4,
    parameter int PAYLOAD_W = 256
);
    logic                        in_valid;
    logic                        in_ready;
    logic [EX_BITS-1:0]          in_ex_type;
    logic [WIS_W-1:0]            in_wis;
    logic                        in_is_vec;
    logic                        in_is_last;
    logic [PAYLOAD_W-1:0]        in_payload;
    logic [NUM_EX-1:0]           out_valid;
    logic [NUM_EX*PAYLOAD_W-1:0] out_payload;
    logic [NUM_EX-1:0]           out_is_last;
    logic [NUM_EX-1:0]           out_ready;
    logic                        err;

    modport master (
        output in_valid, in_ex_type, in_wis, in_is_vec, in_is_last, in_payload, out_ready,
        input  in_ready, out_valid, out_payload, out_is_last, err
    );

    modport slave (
        input  in_valid, in_ex_type, in_wis, in_is_vec, in_is_last, in_payload, out_ready,
        output in_ready, out_valid, out_payload, out_is_last, err
    );
endinterface

// File: rtl/vx_vec_dispatch_router.sv
// Routes operand beats to NUM_EX execute lanes through 2-entry elastic buffers, keeping vector bursts
// contiguous on one lane. Optional perf counters: define VX_VEC_DISPATCH_PERF_EN.
module vx_vec_dispatch_router #(
    parameter int NUM_EX    = 4,
    parameter int EX_BITS   = 2,
    parameter int WIS_W     = 4,
    parameter int PAYLOAD_W = 256,
    parameter int MAX_LANES = 8
) (
    input  logic clk,
    input  logic reset_n,
    vx_vec_dispatch_router_if.slave bus
`ifdef VX_VEC_DISPATCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_vec_bursts
`endif
);
    localparam int LC_W = $clog2(MAX_LANES + 1);

    typedef enum logic {IDLE, VEC_BURST} state_e;

    // Assert asynchronously, release on a clock edge so every flop leaves reset in the same cycle.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    state_e               state;
    logic [EX_BITS-1:0]   lock_ex;
    logic [WIS_W-1:0]     lock_wis;
    logic [LC_W-1:0]      lane_cnt;
    logic                 err_q;

    logic [1:0]           fcnt      [NUM_EX];
    logic [1:0]           occ       [NUM_EX];
    logic [PAYLOAD_W-1:0] head_pl   [NUM_EX];
    logic [PAYLOAD_W-1:0] tail_pl   [NUM_EX];
    logic [NUM_EX-1:0]    head_last;
    logic [NUM_EX-1:0]    tail_last;
    logic [NUM_EX-1:0]    push, pop, fifo_full;

    logic                 in_burst, ex_legal, tgt_full, burst_block;
    logic                 accept, route, lane_cap, beat_last;
    logic [EX_BITS-1:0]   tgt;
    logic [LC_W-1:0]      lane_nxt;

    assign in_burst    = (state == VEC_BURST);
    assign ex_legal    = 32'(bus.in_ex_type) < NUM_EX;
    assign tgt         = in_burst ? lock_ex : bus.in_ex_type;
    assign burst_block = in_burst & ~(bus.in_is_vec & (bus.in_wis == lock_wis));
    assign lane_nxt    = lane_cnt + 1'b1;
    assign lane_cap    = in_burst & (lane_nxt == LC_W'(MAX_LANES));
    assign beat_last   = ~bus.in_is_vec | bus.in_is_last | lane_cap;

    // An illegal target matches no unit, so tgt_full stays 0 and the beat is taken and dropped.
    assign bus.in_ready = rst_n & ~tgt_full & ~burst_block;
    assign accept       = bus.in_valid & bus.in_ready;
    assign route        = accept & (in_burst | ex_legal);

    // NOTE: every always_comb output gets a default before any conditional write so no latch is inferred.
    always_comb begin
        push      = '0;
        pop       = '0;
        fifo_full = '0;
        tgt_full  = 1'b0;
        for (int i = 0; i < NUM_EX; i++) begin
            pop[i]       = (fcnt[i] != 2'd0) & bus.out_ready[i];
            push[i]      = route & (tgt == EX_BITS'(i));
            fifo_full[i] = (fcnt[i] == 2'd2) & ~bus.out_ready[i];
            occ[i]       = fcnt[i] - 2'(pop[i]);
            if (tgt == EX_BITS'(i)) tgt_full = fifo_full[i];
        end
    end

    always_comb begin
        bus.out_valid   = '0;
        bus.out_payload = '0;
        for (int i = 0; i < NUM_EX; i++) begin
            bus.out_valid[i] = (fcnt[i] != 2'd0);
            bus.out_payload[i*PAYLOAD_W +: PAYLOAD_W] = head_pl[i];
        end
    end
    assign bus.out_is_last = head_last;
    assign bus.err         = err_q;

    // NOTE: buffer storage is reset too, because the registered head drives out_payload directly and must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_last <= '0;
            tail_last <= '0;
            for (int i = 0; i < NUM_EX; i++) begin
                fcnt[i]    <= 2'd0;
                head_pl[i] <= '0;
                tail_pl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EX; i++) begin
                fcnt[i] <= fcnt[i] + 2'(push[i]) - 2'(pop[i]);
                if (pop[i] && fcnt[i] == 2'd2) begin
                    head_pl[i]   <= tail_pl[i];
                    head_last[i] <= tail_last[i];
                end
                // A same-cycle pop already moved the tail up, so the push lands in whichever slot is now free.
                if (push[i]) begin
                    if (occ[i] == 2'd0) begin
                        head_pl[i]   <= bus.in_payload;
                        head_last[i] <= beat_last;
                    end else begin
                        tail_pl[i]   <= bus.in_payload;
                        tail_last[i] <= beat_last;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_ex  <= '0;
            lock_wis <= '0;
            lane_cnt <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (!ex_legal) begin
                        err_q <= 1'b1;
                    end else if (bus.in_is_vec && !bus.in_is_last) begin
                        state    <= VEC_BURST;
                        lock_ex  <= bus.in_ex_type;
                        lock_wis <= bus.in_wis;
                        lane_cnt <= LC_W'(1);
                    end
                end
                VEC_BURST: begin
                    if (bus.in_ex_type != lock_ex) err_q <= 1'b1;
                    if (bus.in_is_last) begin
                        state    <= IDLE;
                        lane_cnt <= '0;
                    end else if (lane_cap) begin
                        err_q    <= 1'b1;
                        state    <= IDLE;
                        lane_cnt <= '0;
                    end else begin
                        lane_cnt <= lane_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VX_VEC_DISPATCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_vec_bursts   <= '0;
        end else begin
            if (bus.in_valid && !bus.in_ready)          perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (accept && in_burst && bus.in_is_last)   perf_vec_bursts   <= perf_vec_bursts + 32'd1;
        end
    end
`endif

endmodule

// File: doc/vx_vec_dispatch_router.md
Name: vx_vec_dispatch_router

Overview:
- Sits directly downstream of the operand-collection stage; consumes its valid/data/ready operand stream.
- Routes each operand beat to one of NUM_EX execute-unit lanes, selected by ex_type.
- Each output has a 2-entry elastic buffer.
- Keeps every beat of a multi-lane vector instruction (is_vec, through vd_is_last) contiguous and on one unit: no other beat is accepted until the burst completes.

Parameters:
- NUM_EX, 4, number of execute-unit outputs
- EX_BITS, 2, width of ex_type; NUM_EX <= 2**EX_BITS
- WIS_W, 4, issue-slot (wis) id width
- PAYLOAD_W, 256, opaque payload width (uuid, tmask, PC, op, rs data, rd/vd fields), passed through unmodified
- MAX_LANES, 8, maximum beats per vector burst

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_ex_type  in  EX_BITS  target unit
- in_wis  in  WIS_W  issue slot of beat
- in_is_vec  in  1  beat belongs to vector instruction
- in_is_last  in  1  last lane beat (vd_is_last); ignored when in_is_vec=0
- in_payload  in  PAYLOAD_W  opaque beat payload
- out_valid  out  NUM_EX  per-unit valid
- out_payload  out  NUM_EX*PAYLOAD_W  per-unit payload, unit i at slice i
- out_is_last  out  NUM_EX  per-unit forwarded last flag (1 for scalar beats)
- out_ready  in  NUM_EX  per-unit ready
- err  out  1  sticky protocol error flag

Behaviour:
- Reset (async assert, sync deassert inside block): all FIFOs empty, out_valid=0, out_payload=0, out_is_last=0, FSM=IDLE, lane_cnt=0, err=0. Reset asserted mid-burst discards buffered beats and the burst lock.
- Per-unit FIFO: 2 entries, registered head. Accept-to-out_valid latency is 1 cycle. Full throughput is 1 beat/cycle per unit when out_ready=1. Push and pop in the same cycle on a full FIFO are allowed; the pop frees the slot used by the push.
- Target select: IDLE uses tgt=in_ex_type; VEC_BURST uses tgt=lock_ex.
- in_ready = ~fifo_full[tgt] & ~burst_block, where fifo_full counts a same-cycle pop as freeing a slot.
- Illegal ex_type (>= NUM_EX) in IDLE: in_ready=1, beat dropped, err<=1.
- FSM IDLE:
  - accept with is_vec=1 & is_last=0: go to VEC_BURST; lock_ex<=in_ex_type, lock_wis<=in_wis, lane_cnt<=1.
  - accept with is_vec=1 & is_last=1: single-lane vector; stay IDLE.
  - scalar beat: stay IDLE.
- FSM VEC_BURST:
  - burst_block=1 unless in_is_vec=1 & in_wis==lock_wis. Blocked beats stall with in_ready=0 and are not dropped.
  - Accepted beats route to lock_ex. If in_ex_type != lock_ex: err<=1, beat still routed to lock_ex.
  - Each accept increments lane_cnt.
  - Accept with is_last=1: go to IDLE, lane_cnt<=0.
  - Accept that makes lane_cnt reach MAX_LANES without is_last: err<=1, force IDLE; that beat is forwarded with out_is_last=1.
- out_is_last: in_is_last for vector beats, 1 for scalar beats.
- err is sticky until reset.
- out_valid/out_payload stay stable while out_valid & ~out_ready.
- in_ready is combinational from out_ready, FIFO state and FSM state. It does not depend on in_valid.

Optional Feature:
- Macro VX_VEC_DISPATCH_PERF_EN.
- Defined: adds outputs perf_stall_cycles (32b), counting cycles with in_valid & ~in_ready, and perf_vec_bursts (32b), counting completed multi-lane bursts (exit on is_last). Both counters wrap modulo 2**32 and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Scalar beats with ex_type 0,1,2,3 on consecutive cycles, all out_ready=1 -> each appears on its unit 1 cycle later with out_is_last=1; in_ready stays 1; err=0.
- out_ready[1]=0, 3 scalar beats to unit 1 -> first 2 accepted; in_ready=0 on the 3rd; set out_ready[1]=1 -> drains in order A,B,C with no loss or duplication.
- Vector burst wis=3, ex=2, 4 lanes, is_last on the 4th, interleaved with a scalar beat wis=5 -> scalar stalls until lane 4 accepted, then issues; unit 2 receives 4 lanes in order; out_is_last=1 only on lane 4.
- Burst lane 2 carries ex_type=1 while locked to ex=2 -> routed to unit 2; err=1 and stays 1.
- 8 vector lanes with no is_last (MAX_LANES=8) -> 8th beat forwarded with out_is_last=1; err=1; FSM returns to IDLE; next scalar accepted.
- Assert reset_n=0 mid-burst with both FIFOs holding data -> outputs 0 immediately; after release, a scalar beat to any unit is accepted.
